// File: rtl/conv_pkg.sv
// conv_pkg: constants shared by the column window generator and the
// downstream convolution core.
//   CONV_KERNEL_H  - vertical window height (must match the core)
//   CONV_DRAIN_CYC - core pipeline depth; sets the number of flush pulses
//   ST_*           - column window generator FSM state encodings
//   col_w/row_w    - counter width helpers (never narrower than 1 bit)
package conv_pkg;

  localparam int CONV_KERNEL_H  = 7;
  localparam int CONV_DRAIN_CYC = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_FLUSH  = 2'd3;

  function automatic int col_w(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int row_w(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: one image row of storage, DEPTH x DATA_W.
// The read port is asynchronous, so reading and writing the same address in
// one cycle returns the old contents (read-before-write).
//   i_clk   - clock
//   i_we    - write enable
//   i_addr  - shared read/write address (column)
//   i_wdata - write data
//   o_rdata - contents at i_addr before this cycle's write
module line_buffer_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign o_rdata = mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/col_window_gen.sv
// col_window_gen: raster-order pixel streamer feeding da_conv_core.
// Keeps the previous KERNEL_H-1 rows in line buffers and, for every accepted
// pixel once KERNEL_H rows are available, presents the vertical column ending
// at that pixel. After the last window of a frame it issues DRAIN_CYC extra
// pipe-enable pulses to flush the downstream core.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_valid      - input pixel valid
//   i_sof        - marks pixel (0,0) of a frame
//   i_pixel      - input pixel
//   o_ready      - pixel accepted when i_valid && o_ready
//   o_vector     - column window, [0] = oldest (top) row
//   o_valid      - o_vector holds a new window
//   o_pipe_en    - pipe enable for the downstream core
//   o_eof        - pulses with the last o_valid of a frame
module col_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int KERNEL_H  = CONV_KERNEL_H,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int DRAIN_CYC = CONV_DRAIN_CYC
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  input  logic                             i_sof,
  input  logic [DATA_W-1:0]                i_pixel,
  output logic                             o_ready,
  output logic [KERNEL_H-1:0][DATA_W-1:0]  o_vector,
  output logic                             o_valid,
  output logic                             o_pipe_en,
  output logic                             o_eof
);

  localparam int COL_W = col_w(IMG_W);
  localparam int ROW_W = row_w(IMG_H);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  state_t                           state;
  logic [COL_W-1:0]                 col;
  logic [ROW_W-1:0]                 row;
  logic [DRN_W-1:0]                 drain_cnt;
  logic                             accept;
  logic                             fire;
  logic                             col_last;
  logic                             row_last;
  logic                             wr_en;
  logic [COL_W-1:0]                 addr;
  logic [KERNEL_H-2:0][DATA_W-1:0]  rd_data;
  logic [KERNEL_H-2:0][DATA_W-1:0]  wr_data;
  logic [KERNEL_H-1:0][DATA_W-1:0]  next_vec;

  assign o_ready  = (state != ST_FLUSH);
  assign accept   = i_valid && o_ready;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));

  // A start-of-frame pixel aborts whatever was in progress, so it never
  // produces a window even when it arrives during STREAM.
  assign fire = accept && !i_sof && (state == ST_STREAM);

  // Pixels dropped in IDLE are not stored; an SOF pixel always lands at column 0
  // regardless of where the aborted frame left the counter.
  assign wr_en = accept && (i_sof || (state != ST_IDLE));
  assign addr  = i_sof ? '0 : col;

  // o_valid is exactly the registered "accepted in STREAM" strobe.
  assign o_pipe_en = o_valid || (state == ST_FLUSH);

  // Buffer 0 takes the new pixel, each deeper buffer takes the row its
  // neighbour held before this write, so buffer k holds row (current-1-k).
  for (genvar k = 0; k < KERNEL_H - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign wr_data[k] = i_pixel;
    end else begin : g_chain
      assign wr_data[k] = rd_data[k-1];
    end
    line_buffer_ram #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
    ) u_ram (
      .i_clk   (i_clk),
      .i_we    (wr_en),
      .i_addr  (addr),
      .i_wdata (wr_data[k]),
      .o_rdata (rd_data[k])
    );
  end

  // Deepest buffer is the oldest row and goes to the top of the window.
  always_comb begin
    next_vec = '0;
    next_vec[KERNEL_H-1] = i_pixel;
    for (int j = 0; j < KERNEL_H - 1; j++) begin
      next_vec[j] = rd_data[KERNEL_H-2-j];
    end
  end

  // FLUSH lasts DRAIN_CYC+1 cycles: its first cycle carries the final window,
  // the remaining DRAIN_CYC cycles are the pure drain pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
      o_valid   <= 1'b0;
      o_eof     <= 1'b0;
      o_vector  <= '0;
    end else begin
      o_valid <= fire;
      o_eof   <= fire && row_last && col_last;
      if (fire) o_vector <= next_vec;

      case (state)
        ST_IDLE: begin
          if (accept && i_sof) begin
            row   <= '0;
            col   <= COL_W'(1);
            state <= ST_FILL;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (accept) begin
            if (i_sof) begin
              row   <= '0;
              col   <= COL_W'(1);
              state <= ST_FILL;
            end else begin
              if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if ((state == ST_FILL) && col_last && (row == ROW_W'(KERNEL_H - 2))) begin
                state <= ST_STREAM;
              end
              if ((state == ST_STREAM) && col_last && row_last) begin
                row       <= '0;
                drain_cnt <= '0;
                state     <= ST_FLUSH;
              end
            end
          end
        end
        default: begin
          if (drain_cnt == DRN_W'(DRAIN_CYC)) begin
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_col_window_gen.sv
// tb_col_window_gen: directed bench for col_window_gen with an 8x10 image,
// 7-row kernel and pixel value row*16+col (optionally XOR-masked so that a
// second frame carries different data). Frame pixels are driven cycle by
// cycle against a small window model; flush tails are checked from a table.
module tb_col_window_gen;

  localparam int DATA_W    = 8;
  localparam int KERNEL_H  = 7;
  localparam int IMG_W     = 8;
  localparam int IMG_H     = 10;
  localparam int DRAIN_CYC = 3;
  localparam int NPIX      = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst;
  logic valid;
  logic sof;
  logic [DATA_W-1:0] pixel;
  logic ready;
  logic [KERNEL_H-1:0][DATA_W-1:0] vec;
  logic ovalid;
  logic pipeEn;
  logic eof;

  int passCount  = 0;
  int checkCount = 0;
  int validSeen  = 0;

  logic expFire = 1'b0;
  logic expEof  = 1'b0;
  logic [KERNEL_H*DATA_W-1:0] expVec = '0;

  typedef struct {
    logic       rst;
    logic       v;
    logic       s;
    logic [7:0] p;
    logic       expReady;
    logic       expValid;
    logic       expPipe;
    logic       expEof;
    logic       chkVec;
  } vecRec_t;

  vecRec_t tbl [11];

  col_window_gen #(
    .DATA_W    (DATA_W),
    .KERNEL_H  (KERNEL_H),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_sof     (sof),
    .i_pixel   (pixel),
    .o_ready   (ready),
    .o_vector  (vec),
    .o_valid   (ovalid),
    .o_pipe_en (pipeEn),
    .o_eof     (eof)
  );

  always #5 clk = ~clk;

  // Counts window strobes so a whole frame's output count can be checked.
  always @(negedge clk) begin
    if (ovalid === 1'b1) validSeen++;
  end

  // Safety net: the bench never waits on DUT events, but never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] mask);
    return 8'(r * 16 + c) ^ mask;
  endfunction

  function automatic logic [KERNEL_H*DATA_W-1:0] expVector(input int r, input int c,
                                                           input logic [7:0] mask);
    logic [KERNEL_H-1:0][DATA_W-1:0] v;
    for (int j = 0; j < KERNEL_H; j++) v[j] = pix(r - (KERNEL_H - 1) + j, c, mask);
    return v;
  endfunction

  function automatic vecRec_t mkRec(input logic v, input logic s, input logic [7:0] p,
                                    input logic er, input logic ev, input logic ep,
                                    input logic ee);
    vecRec_t rec;
    rec.rst = 1'b0; rec.v = v; rec.s = s; rec.p = p;
    rec.expReady = er; rec.expValid = ev; rec.expPipe = ep; rec.expEof = ee;
    rec.chkVec = 1'b1;
    return rec;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  // One cycle of frame traffic: drive inputs, check the response to the
  // previous cycle, then predict the response to this one.
  task automatic applyStimulus(input logic r, input logic v, input logic s,
                               input logic [7:0] p, input logic inStream,
                               input logic lastPix,
                               input logic [KERNEL_H*DATA_W-1:0] vecIfFire);
    rst = r; valid = v; sof = s; pixel = p;
    @(negedge clk);
    checkOutput("o_valid", 64'(ovalid), 64'(expFire));
    checkOutput("o_pipe_en", 64'(pipeEn), 64'(expFire));
    checkOutput("o_eof", 64'(eof), 64'(expEof));
    checkOutput("o_ready", 64'(ready), 64'd1);
    if (expFire) checkOutput("o_vector", 64'(vec), 64'(expVec));
    expFire = !r && v && !s && inStream;
    expEof  = !r && v && !s && inStream && lastPix;
    if (expFire) expVec = vecIfFire;
    @(posedge clk); #1;
  endtask

  task automatic sendFrame(input int first, input int last, input logic [7:0] mask,
                           input int throttle);
    int r;
    int c;
    int gaps;
    for (int i = first; i < last; i++) begin
      r = i / IMG_W;
      c = i % IMG_W;
      gaps = 0;
      while (throttle > 0 && $urandom_range(99, 0) < throttle && gaps < 8) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, '0);
        gaps++;
      end
      applyStimulus(1'b0, 1'b1, (i == 0), pix(r, c, mask), (r >= KERNEL_H - 1),
                    (i == NPIX - 1), expVector(r, c, mask));
    end
  endtask

  task automatic runTable(input int lo, input int hi,
                          input logic [KERNEL_H*DATA_W-1:0] heldVec);
    for (int i = lo; i <= hi; i++) begin
      rst = tbl[i].rst; valid = tbl[i].v; sof = tbl[i].s; pixel = tbl[i].p;
      @(negedge clk);
      checkOutput($sformatf("tbl%0d o_ready", i), 64'(ready), 64'(tbl[i].expReady));
      checkOutput($sformatf("tbl%0d o_valid", i), 64'(ovalid), 64'(tbl[i].expValid));
      checkOutput($sformatf("tbl%0d o_pipe_en", i), 64'(pipeEn), 64'(tbl[i].expPipe));
      checkOutput($sformatf("tbl%0d o_eof", i), 64'(eof), 64'(tbl[i].expEof));
      if (tbl[i].chkVec) checkOutput($sformatf("tbl%0d o_vector", i), 64'(vec), 64'(heldVec));
      @(posedge clk); #1;
    end
    expFire = 1'b0;
    expEof  = 1'b0;
  endtask

  initial begin
    int startSeen;

    // Records 0-4: end-of-frame tail with idle input.
    tbl[0] = mkRec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[1] = mkRec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[2] = mkRec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[3] = mkRec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[4] = mkRec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // Records 5-10: tail with an SOF pixel held off until FLUSH ends.
    tbl[5]  = mkRec(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[6]  = mkRec(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mkRec(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mkRec(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mkRec(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[10] = mkRec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; valid = 1'b0; sof = 1'b0; pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset o_valid", 64'(ovalid), 64'd0);
    checkOutput("reset o_pipe_en", 64'(pipeEn), 64'd0);
    checkOutput("reset o_eof", 64'(eof), 64'd0);
    checkOutput("reset o_vector", 64'(vec), 64'd0);
    checkOutput("reset o_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] discarded pixels then full frame");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i), 1'b0, 1'b0, '0);
    end
    startSeen = validSeen;
    sendFrame(0, NPIX, 8'h00, 0);
    runTable(0, 4, expVector(IMG_H - 1, IMG_W - 1, 8'h00));
    checkOutput("window count", 64'(validSeen - startSeen),
                64'((IMG_H - KERNEL_H + 1) * IMG_W));

    $display("[TB] throttled frame");
    sendFrame(0, NPIX, 8'h00, 50);
    runTable(0, 4, expVector(IMG_H - 1, IMG_W - 1, 8'h00));

    $display("[TB] SOF abort at (7,3)");
    sendFrame(0, 7 * IMG_W + 3, 8'h00, 0);
    sendFrame(0, NPIX, 8'h08, 0);
    runTable(0, 4, expVector(IMG_H - 1, IMG_W - 1, 8'h08));

    $display("[TB] reset at (8,2), then SOF during FLUSH");
    sendFrame(0, 8 * IMG_W + 2, 8'h00, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, pix(8, 2, 8'h00), 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    sendFrame(0, NPIX, 8'h00, 0);
    runTable(5, 10, expVector(IMG_H - 1, IMG_W - 1, 8'h00));
    sendFrame(1, NPIX, 8'h00, 0);
    runTable(0, 4, expVector(IMG_H - 1, IMG_W - 1, 8'h00));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
